// File: rtl/arb_mux.sv
// Registered N:1 channel multiplexer with fixed-priority or round-robin arbitration.
// A one-word output register gives ready/valid flow control and one-word-per-cycle throughput.
module arb_mux #(
  parameter int N    = 32,
  parameter int CH   = 4,
  parameter int MODE = 1,
  localparam int SW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   in_valid,
  input  logic [CH*N-1:0] in_data,
  output logic [CH-1:0]   in_ready,
  output logic            out_valid,
  output logic [N-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  input  logic            out_ready,
  output logic [7:0]      grant_cnt
);

  logic          load_en;
  logic          accept;
  logic          found;
  logic [CH-1:0] grant;
  logic [SW-1:0] gidx;
  logic [SW-1:0] pos;
  logic [SW-1:0] ptr;
  logic [N-1:0]  sel_data;

  assign load_en = !out_valid || out_ready;

  // Search order starts at ptr in round-robin mode and at channel 0 otherwise.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < CH; k++) begin
      if (MODE == 1) begin
        pos = SW'((int'(ptr) + k) % CH);
      end else begin
        pos = SW'(k);
      end
      if (!found && in_valid[pos]) begin
        grant[pos] = 1'b1;
        gidx       = pos;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant[i]) begin
        sel_data = in_data[i*N +: N];
      end
    end
  end

  // Reset gating keeps every channel stalled while the output register is cleared.
  assign in_ready = grant & {CH{load_en & rst}};
  assign accept   = |in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load_en) begin
      out_valid <= accept;
      if (accept) begin
        out_data <= sel_data;
        out_sel  <= gidx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (MODE == 1 && accept) begin
      if (int'(gidx) == CH - 1) begin
        ptr <= '0;
      end else begin
        ptr <= gidx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt <= '0;
    end else if (accept && grant_cnt != 8'hFF) begin
      grant_cnt <= grant_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: a round-robin and a fixed-priority instance share stimulus and
// are compared against a rotate-and-scan reference model plus directed sequences.
module tb_arb_mux;
  localparam int N  = 32;
  localparam int CH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   inValid = '0;
  logic [127:0] inData = '0;
  logic         outReady = 1'b0;

  logic [3:0]  ir1, ir0;
  logic        ov1, ov0;
  logic [31:0] od1, od0;
  logic [1:0]  os1, os0;
  logic [7:0]  gc1, gc0;

  int checks = 0;
  int failures = 0;

  logic [1:0]  mPtr[2];
  bit          mValid[2];
  logic [31:0] mData[2];
  logic [1:0]  mSel[2];
  int          mCnt[2];

  typedef struct {
    logic [3:0] inValid;
    logic       outReady;
    logic [1:0] sel1;
    logic [1:0] sel0;
    logic       valid;
    int         cnt;
  } vec_t;

  vec_t tbl[10];

  arb_mux #(.N(N), .CH(CH), .MODE(1)) dutRr (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_data(inData), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(outReady), .grant_cnt(gc1)
  );

  arb_mux #(.N(N), .CH(CH), .MODE(0)) dutFp (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_data(inData), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(outReady), .grant_cnt(gc0)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] chanData(input int i);
    return inData[i*32 +: 32];
  endfunction

  // Reference: rotate the request vector so the search start sits at bit 0, then
  // take the lowest set bit and map it back to a channel number.
  function automatic logic [3:0] modelReady(input int m);
    int         start;
    logic [7:0] twice;
    logic [3:0] rot;
    start = (m == 1) ? int'(mPtr[m]) : 0;
    twice = {inValid, inValid};
    rot   = 4'(twice >> start);
    if (!rst || !(!mValid[m] || outReady) || rot == 4'd0) return 4'd0;
    for (int j = 0; j < 4; j++) begin
      if (rot[j]) return 4'(1 << ((start + j) % 4));
    end
    return 4'd0;
  endfunction

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      mPtr[m] = '0; mValid[m] = 1'b0; mData[m] = '0; mSel[m] = '0; mCnt[m] = 0;
    end
  endtask

  task automatic modelEdge(input int m, input logic [3:0] r);
    int g;
    g = 0;
    if (r != 4'd0) begin
      for (int j = 0; j < 4; j++) if (r[j]) g = j;
      mValid[m] = 1'b1;
      mData[m]  = chanData(g);
      mSel[m]   = 2'(g);
      if (mCnt[m] < 255) mCnt[m]++;
      if (m == 1) mPtr[m] = 2'((g + 1) % 4);
    end else if (!mValid[m] || outReady) begin
      mValid[m] = 1'b0;
    end
  endtask

  task automatic compareState(input int m);
    checkOutput($sformatf("dut%0d out_valid", m), m ? ov1 : ov0, mValid[m]);
    checkOutput($sformatf("dut%0d out_data", m), m ? od1 : od0, mData[m]);
    checkOutput($sformatf("dut%0d out_sel", m), m ? os1 : os0, mSel[m]);
    checkOutput($sformatf("dut%0d grant_cnt", m), m ? gc1 : gc0, 64'(mCnt[m]));
  endtask

  // One clock cycle with the currently driven inputs, checked against the model.
  task automatic applyStimulus();
    logic [3:0] r[2];
    #2;
    for (int m = 0; m < 2; m++) begin
      r[m] = modelReady(m);
      checkOutput($sformatf("dut%0d in_ready", m), m ? ir1 : ir0, r[m]);
    end
    @(posedge clk);
    if (rst) for (int m = 0; m < 2; m++) modelEdge(m, r[m]);
    #1;
    for (int m = 0; m < 2; m++) compareState(m);
  endtask

  task automatic doReset();
    inValid  = '0;
    outReady = 1'b0;
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    for (int m = 0; m < 2; m++) compareState(m);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{4'b1111, 1'b1, 2'd0, 2'd0, 1'b1, 1};
    tbl[1] = '{4'b1111, 1'b1, 2'd1, 2'd0, 1'b1, 2};
    tbl[2] = '{4'b1111, 1'b1, 2'd2, 2'd0, 1'b1, 3};
    tbl[3] = '{4'b1111, 1'b1, 2'd3, 2'd0, 1'b1, 4};
    tbl[4] = '{4'b1111, 1'b1, 2'd0, 2'd0, 1'b1, 5};
    tbl[5] = '{4'b1010, 1'b1, 2'd1, 2'd1, 1'b1, 6};
    tbl[6] = '{4'b1010, 1'b1, 2'd3, 2'd1, 1'b1, 7};
    tbl[7] = '{4'b1010, 1'b1, 2'd1, 2'd1, 1'b1, 8};
    tbl[8] = '{4'b0000, 1'b1, 2'd1, 2'd1, 1'b0, 8};
    tbl[9] = '{4'b0101, 1'b0, 2'd2, 2'd0, 1'b1, 9};

    modelReset();
    #2;
    checkOutput("reset in_ready", ir1, 4'd0);
    doReset();

    inData = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    for (int i = 0; i < 10; i++) begin
      inValid  = tbl[i].inValid;
      outReady = tbl[i].outReady;
      applyStimulus();
      checkOutput($sformatf("tbl%0d sel rr", i), os1, tbl[i].sel1);
      checkOutput($sformatf("tbl%0d sel fp", i), os0, tbl[i].sel0);
      checkOutput($sformatf("tbl%0d valid", i), ov1, tbl[i].valid);
      checkOutput($sformatf("tbl%0d cnt", i), gc1, 64'(tbl[i].cnt));
      checkOutput($sformatf("tbl%0d data", i), od1, 32'(32'h11111111 * (int'(tbl[i].sel1) + 1)));
    end

    // Backpressure: held word survives five stalled cycles, then drains and refills together.
    inData[31:0] = 32'hDEADBEEF;
    inValid  = 4'b0001;
    outReady = 1'b1;
    applyStimulus();
    checkOutput("bp load", od1, 32'hDEADBEEF);
    inData[31:0] = 32'h12345678;
    outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("bp hold data", od1, 32'hDEADBEEF);
      checkOutput("bp hold ready", ir1, 4'd0);
    end
    outReady = 1'b1;
    #1;
    checkOutput("bp release ready", ir1, 4'b0001);
    applyStimulus();
    checkOutput("bp next data", od1, 32'h12345678);

    // Pointer wrap: grant to 2 leaves ptr=3, so 0101 goes to 0 then 2.
    inValid = 4'b0100;
    applyStimulus();
    checkOutput("wrap g2", os1, 2'd2);
    inValid = 4'b0101;
    applyStimulus();
    checkOutput("wrap g0", os1, 2'd0);
    applyStimulus();
    checkOutput("wrap g2 again", os1, 2'd2);

    // Asynchronous reset between edges with a word held and seven grants counted.
    doReset();
    inValid  = 4'b1111;
    outReady = 1'b1;
    repeat (7) applyStimulus();
    checkOutput("pre-reset cnt", gc1, 8'd7);
    outReady = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async out_valid", ov1, 1'b0);
    checkOutput("async grant_cnt", gc1, 8'd0);
    checkOutput("async in_ready", ir1, 4'd0);
    checkOutput("async out_sel", os1, 2'd0);
    checkOutput("async out_data", od1, 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("reset held over edge", ov1, 1'b0);
    #2;
    rst      = 1'b1;
    inValid  = 4'b1000;
    outReady = 1'b1;
    applyStimulus();
    checkOutput("post-reset sel rr", os1, 2'd3);
    checkOutput("post-reset sel fp", os0, 2'd3);

    // Saturation of the grant counter.
    inValid = 4'b1111;
    for (int i = 0; i < 300; i++) begin
      inData = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus();
    end
    checkOutput("cnt saturated", gc1, 8'd255);
    applyStimulus();
    checkOutput("cnt stays saturated", gc1, 8'd255);

    for (int i = 0; i < 1500; i++) begin
      inValid  = 4'($urandom_range(0, 15));
      outReady = ($urandom_range(0, 3) != 0);
      inData   = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 199) == 0) begin
        doReset();
        inValid  = 4'($urandom_range(0, 15));
        outReady = 1'b1;
      end
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
